// File: rtl/selfcorrecting_counter_pkg.sv
// Shared glyph constants, digit type and glyph lookup for the self-correcting
// cascaded BCD-style counter.
package selfcorrecting_counter_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_glyph(input digit_t i_d);
    case (i_d)
      4'd0:    seg_glyph = SEG_0;
      4'd1:    seg_glyph = SEG_1;
      4'd2:    seg_glyph = SEG_2;
      4'd3:    seg_glyph = SEG_3;
      4'd4:    seg_glyph = SEG_4;
      4'd5:    seg_glyph = SEG_5;
      4'd6:    seg_glyph = SEG_6;
      4'd7:    seg_glyph = SEG_7;
      4'd8:    seg_glyph = SEG_8;
      4'd9:    seg_glyph = SEG_9;
      default: seg_glyph = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/selfcorrecting_counter_seg7_decode.sv
// One-digit 7-segment decoder: codes above MAX_DIGIT show a dash, blank
// suppresses a legal glyph.
module seg7_decode
  import selfcorrecting_counter_pkg::*;
#(
  parameter int MAX_DIGIT = 9
) (
  input  digit_t     i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  localparam digit_t MAX_D = digit_t'(MAX_DIGIT);

  // Dash wins over blanking so a corrupted digit is always visible
  always_comb begin
    if (i_digit > MAX_D) begin
      o_seg = SEG_DASH;
    end else if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = seg_glyph(i_digit);
    end
  end

endmodule

// File: rtl/selfcorrecting_counter.sv
// Cascaded up/down digit counter that clears illegal digit codes in one cycle.
// Optional leading-zero blanking with `define LEADING_ZERO_BLANK_EN.
module selfcorrecting_counter
  import selfcorrecting_counter_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MAX_DIGIT = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  x,
  input  logic                  en,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_val,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tc,
  output logic                  err
);

  localparam digit_t MAX_D = digit_t'(MAX_DIGIT);

  digit_t              r_digit [DIGITS];
  digit_t              w_next  [DIGITS];
  logic [DIGITS-1:0]   w_illegal;
  logic [DIGITS-1:0]   w_is_max;
  logic [DIGITS-1:0]   w_is_zero;
  logic [DIGITS-1:0]   w_low_max;
  logic [DIGITS-1:0]   w_low_zero;
  logic [DIGITS-1:0]   w_blank;
  logic                w_any_illegal;

  // Per-digit classification and ripple enables from the lower digits
  always_comb begin
    logic v_max_acc;
    logic v_zero_acc;
    w_illegal  = '0;
    w_is_max   = '0;
    w_is_zero  = '0;
    w_low_max  = '0;
    w_low_zero = '0;
    v_max_acc  = 1'b1;
    v_zero_acc = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      w_illegal[k]  = (r_digit[k] > MAX_D);
      w_is_max[k]   = (r_digit[k] == MAX_D);
      w_is_zero[k]  = (r_digit[k] == 4'd0);
      w_low_max[k]  = v_max_acc;
      w_low_zero[k] = v_zero_acc;
      v_max_acc     = v_max_acc & w_is_max[k];
      v_zero_acc    = v_zero_acc & w_is_zero[k];
    end
  end

  assign w_any_illegal = |w_illegal;
  assign err = w_any_illegal;
  assign tc  = en & ~ld & ~w_any_illegal &
               ((x & (&w_is_max)) | (~x & (&w_is_zero)));

  // Leading-zero blanking walks down from the most significant digit
  always_comb begin
    w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic v_above_zero;
      v_above_zero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
        w_blank[k]   = w_is_zero[k] & v_above_zero;
        v_above_zero = v_above_zero & w_is_zero[k];
      end
    end
`else
    w_blank = '0;
`endif
  end

  // Next state: load, then correction (which suppresses counting), then count
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      w_next[k] = r_digit[k];
      if (ld) begin
        w_next[k] = ld_val[4*k +: 4];
      end else if (w_any_illegal) begin
        w_next[k] = w_illegal[k] ? 4'd0 : r_digit[k];
      end else if (en && x && w_low_max[k]) begin
        w_next[k] = w_is_max[k] ? 4'd0 : r_digit[k] + 4'd1;
      end else if (en && !x && w_low_zero[k]) begin
        w_next[k] = w_is_zero[k] ? MAX_D : r_digit[k] - 4'd1;
      end else begin
        w_next[k] = r_digit[k];
      end
    end
  end

  // Digit state registers with synchronous reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < DIGITS; k++) begin
      if (reset) begin
        r_digit[k] <= 4'd0;
      end else begin
        r_digit[k] <= w_next[k];
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode #(.MAX_DIGIT(MAX_DIGIT)) u_dec (
      .i_digit (r_digit[g]),
      .i_blank (w_blank[g]),
      .o_seg   (seg[7*g +: 7])
    );
  end

endmodule
